next_pc_unit: RTL and testbench
===============================

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC/target width in bits.
REQ-002 SHALL have parameter JADDR_W, default 26, jump-address field width.
REQ-003 SHALL have parameter IMM_W, default 16, branch-immediate width.
REQ-004 SHALL have parameter SHIFT, default 2, word-alignment left shift.
REQ-005 SHALL have parameter RESET_PC, default 0, PC value loaded by reset.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port fetch_ready  input  1  fetch stage accepts current pc.
REQ-009 SHALL have port branch_taken  input  1  take branch relative to pc.
REQ-010 SHALL have port branch_imm  input  IMM_W  signed word offset.
REQ-011 SHALL have port jump  input  1  absolute jump request.
REQ-012 SHALL have port jump_addr  input  JADDR_W  jump field.
REQ-013 SHALL have port jr  input  1  jump-register request.
REQ-014 SHALL have port jr_target  input  ADDR_W  register target.
REQ-015 SHALL have port pc  output  ADDR_W  registered current PC.
REQ-016 SHALL have port pc_valid  output  1  pc presentable to fetch.
REQ-017 SHALL have port jump_target  output  ADDR_W  combinational jump target for current pc.
REQ-018 SHALL have port redirect_pending  output  1  a redirect is latched awaiting fetch_ready.

Function
REQ-019 pc_plus SHALL equal pc + 2^SHIFT modulo 2^ADDR_W.
REQ-020 jump_target SHALL equal {pc_plus[ADDR_W-1:JADDR_W+SHIFT], jump_addr, SHIFT zero bits}; no upper bits when ADDR_W == JADDR_W+SHIFT; elaboration SHALL fail if ADDR_W < JADDR_W+SHIFT.
REQ-021 Branch target SHALL equal pc_plus + (sign-extended branch_imm << SHIFT), modulo 2^ADDR_W.
REQ-022 Next-PC priority SHALL be jr > jump > branch_taken > pc_plus; a redirect is any of jr, jump, branch_taken high.
REQ-023 FSM states SHALL be BOOT, RUN, HOLD; reset enters BOOT.
REQ-024 BOOT: first edge with reset low SHALL set pc_valid=1, keep pc=RESET_PC, go RUN; inputs ignored in BOOT.
REQ-025 RUN, fetch_ready=1: pc SHALL load selected next PC on that edge (latency one cycle).
REQ-026 RUN, fetch_ready=0, no redirect: pc SHALL hold.
REQ-027 RUN, fetch_ready=0, redirect: target SHALL be latched into pending register, go HOLD, redirect_pending=1, pc held.
REQ-028 HOLD, fetch_ready=0, new redirect: pending SHALL be overwritten (newest wins), computed from held pc.
REQ-029 HOLD, fetch_ready=1, no redirect: pc SHALL load pending, go RUN, redirect_pending=0.
REQ-030 HOLD, fetch_ready=1 and redirect same cycle: pc SHALL load the new redirect target, pending discarded, go RUN.
REQ-031 pc_valid SHALL remain 1 in RUN and HOLD.

Reset
REQ-032 reset high SHALL immediately force pc=RESET_PC, pc_valid=0, redirect_pending=0, pending=0, state BOOT, including mid-HOLD (pending lost).

Configuration
REQ-033 With NEXT_PC_JR_EN defined, jr/jr_target SHALL participate per REQ-022; without it, ports SHALL exist but be ignored and jr not count as redirect.

Structure
REQ-034 Package next_pc_pkg SHALL hold the FSM state enum and next-PC select encoding.
REQ-035 Sub-module jump_target_calc SHALL implement REQ-020 combinationally, parametrised by ADDR_W, JADDR_W, SHIFT.

Verification
REQ-036 reset=1 -> pc=0, pc_valid=0; release -> after one edge pc_valid=1, pc=0.
REQ-037 fetch_ready=1 for three edges, no redirect -> pc 0x4, 0x8, 0xC.
REQ-038 pc=0x40000004, jump=1, jump_addr=26'h3FFFFFF -> jump_target=0x4FFFFFFC, next pc 0x4FFFFFFC; pc=0, jump_addr=26'h2BCDF11 -> 0x0AF37C44.
REQ-039 pc=0x100, branch_taken=1, branch_imm=16'hFFFF -> next pc 0x100.
REQ-040 pc=0x10, fetch_ready=0, jump_addr=0x20 -> redirect_pending=1, pc holds 0x10 two cycles; fetch_ready=1 -> pc=0x80, redirect_pending=0; repeat with reset asserted in HOLD -> pc=0, pending cleared.
REQ-041 With NEXT_PC_JR_EN, jr=1, jr_target=0x2000, jump=1 same cycle -> pc=0x2000; without macro -> jump target taken.

Source files
------------

// File: rtl/next_pc_pkg.sv
// Shared types for the next-PC unit: FSM states and next-PC source select.
package next_pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    SEL_PLUS,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_JR
  } sel_t;

  // jr beats jump beats branch; otherwise fall through to pc_plus
  function automatic sel_t pick_sel(
    input logic jr,
    input logic jump,
    input logic branch
  );
    sel_t s;
    s = SEL_PLUS;
    if (branch) s = SEL_BRANCH;
    if (jump)   s = SEL_JUMP;
    if (jr)     s = SEL_JR;
    return s;
  endfunction

endpackage

// File: rtl/jump_target_calc.sv
// Absolute jump target: upper pc_plus bits, jump field, word-aligned low zeros.
module jump_target_calc #(
  parameter int ADDR_W  = 32,
  parameter int JADDR_W = 26,
  parameter int SHIFT   = 2
) (
  input  logic [ADDR_W-1:0]  pc_plus,
  input  logic [JADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0]  target
);

  localparam int LOW = JADDR_W + SHIFT;

  logic [ADDR_W-1:0] low_part;
  logic              unused_low;

  assign low_part   = ADDR_W'(jump_addr) << SHIFT;
  assign unused_low = ^pc_plus[LOW-1:0];

  if (ADDR_W < LOW) begin : g_bad
    $error("jump_target_calc: ADDR_W must be >= JADDR_W + SHIFT");
  end else if (ADDR_W == LOW) begin : g_exact
    assign target = low_part;
  end else begin : g_upper
    assign target = {pc_plus[ADDR_W-1:LOW], low_part[LOW-1:0]};
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC selection and PC register with fetch back-pressure.
// Define NEXT_PC_JR_EN to enable the jump-register path.
module next_pc_unit
  import next_pc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int JADDR_W = 26,
  parameter int IMM_W   = 16,
  parameter int SHIFT   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_ready,
  input  logic               branch_taken,
  input  logic [IMM_W-1:0]   branch_imm,
  input  logic               jump,
  input  logic [JADDR_W-1:0] jump_addr,
  input  logic               jr,
  input  logic [ADDR_W-1:0]  jr_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               pc_valid,
  output logic [ADDR_W-1:0]  jump_target,
  output logic               redirect_pending
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(1) << SHIFT;

  state_t            state;
  sel_t              sel;
  logic [ADDR_W-1:0] pc_plus;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jr_path;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] pending;
  logic              jr_act;
  logic              redirect;

`ifdef NEXT_PC_JR_EN
  assign jr_act  = jr;
  assign jr_path = jr_target;
`else
  logic unused_jr;
  assign jr_act    = 1'b0;
  assign jr_path   = '0;
  assign unused_jr = ^{jr, jr_target};
`endif

  assign pc_plus       = pc + STEP;
  assign branch_target = pc_plus
                       + (ADDR_W'($signed(branch_imm)) << SHIFT);

  jump_target_calc #(
    .ADDR_W  (ADDR_W),
    .JADDR_W (JADDR_W),
    .SHIFT   (SHIFT)
  ) u_jump_target (
    .pc_plus   (pc_plus),
    .jump_addr (jump_addr),
    .target    (jump_target)
  );

  assign redirect = jr_act | jump | branch_taken;
  assign sel      = pick_sel(jr_act, jump, branch_taken);

  always_comb begin
    next_pc = pc_plus;
    unique case (sel)
      SEL_JR:     next_pc = jr_path;
      SEL_JUMP:   next_pc = jump_target;
      SEL_BRANCH: next_pc = branch_target;
      default:    next_pc = pc_plus;
    endcase
  end

  // A redirect seen while fetch stalls is parked in pending; newest wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= BOOT;
      pc               <= RESET_PC;
      pc_valid         <= 1'b0;
      redirect_pending <= 1'b0;
      pending          <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          pc_valid <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          if (fetch_ready) begin
            pc <= next_pc;
          end else if (redirect) begin
            pending          <= next_pc;
            redirect_pending <= 1'b1;
            state            <= HOLD;
          end
        end
        HOLD: begin
          if (fetch_ready) begin
            pc               <= redirect ? next_pc : pending;
            pending          <= '0;
            redirect_pending <= 1'b0;
            state            <= RUN;
          end else if (redirect) begin
            pending <= next_pc;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit.
module tb_next_pc_unit;

  typedef struct {
    string       name;
    logic        fr;
    logic        br;
    logic [15:0] imm;
    logic        j;
    logic [25:0] ja;
    logic [31:0] epc;
    logic        erp;
  } stim_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        rp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_ready;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_addr;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] jump_target;
  logic        redirect_pending;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  next_pc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_ready      (fetch_ready),
    .branch_taken     (branch_taken),
    .branch_imm       (branch_imm),
    .jump             (jump),
    .jump_addr        (jump_addr),
    .jr               (jr),
    .jr_target        (jr_target),
    .pc               (pc),
    .pc_valid         (pc_valid),
    .jump_target      (jump_target),
    .redirect_pending (redirect_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t mk(string n, logic fr, logic br,
                               logic [15:0] imm, logic j,
                               logic [25:0] ja, logic [31:0] epc,
                               logic erp);
    stim_t s;
    s.name = n; s.fr = fr; s.br = br; s.imm = imm;
    s.j = j; s.ja = ja; s.epc = epc; s.erp = erp;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    fetch_ready  = s.fr;
    branch_taken = s.br;
    branch_imm   = s.imm;
    jump         = s.j;
    jump_addr    = s.ja;
    jr           = 1'b0;
    jr_target    = '0;
  endtask

  task automatic idle();
    apply(mk("idle", 0, 0, 16'h0, 0, 26'h0, 32'h0, 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || redirect_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h pv=%b rp=%b want pc=0 pv=0 rp=0",
               pc, pc_valid, redirect_pending);
    end
    apply(mk("boot", 1, 0, 16'h0, 1, 26'h40, 32'h0, 0));
    #2;
    reset = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b1 || redirect_pending !== 1'b0) begin
      errors++;
      $display("FAIL boot_exit: pc=%h pv=%b rp=%b want pc=0 pv=1 rp=0",
               pc, pc_valid, redirect_pending);
    end
    idle();
  endtask

  task automatic test_sequential();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk("seq1", 1, 0, 16'h0, 0, 26'h0, 32'h4, 0));
    st.push_back(mk("seq2", 1, 0, 16'h0, 0, 26'h0, 32'h8, 0));
    st.push_back(mk("seq3", 1, 0, 16'h0, 0, 26'h0, 32'hC, 0));
    st.push_back(mk("seq_stall", 0, 0, 16'h0, 0, 26'h0, 32'hC, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back('{st[i].name, st[i].epc, st[i].erp});
      tick();
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || redirect_pending !== e.rp || pc_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s: pc=%h rp=%b pv=%b want pc=%h rp=%b pv=1",
                 e.name, pc, redirect_pending, pc_valid, e.pc, e.rp);
      end
    end
  endtask

  task automatic test_jump();
    stim_t st[$];
    exp_t  e;
    logic [31:0] up;
    // climb the upper nibble through pc_plus carries
    for (int k = 0; k < 4; k++) begin
      up = 32'(k) << 28;
      st.push_back(mk("jclimb_hi", 1, 0, 16'h0, 1, 26'h3FFFFFF,
                      up | 32'h0FFFFFFC, 0));
      st.push_back(mk("jclimb_carry", 1, 0, 16'h0, 1, 26'h0,
                      up + 32'h10000000, 0));
    end
    st.push_back(mk("jclimb_step", 1, 0, 16'h0, 0, 26'h0, 32'h40000004, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back('{st[i].name, st[i].epc, st[i].erp});
      tick();
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || redirect_pending !== e.rp || pc_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s: pc=%h rp=%b pv=%b want pc=%h rp=%b pv=1",
                 e.name, pc, redirect_pending, pc_valid, e.pc, e.rp);
      end
    end
    apply(mk("jupper", 1, 0, 16'h0, 1, 26'h3FFFFFF, 32'h4FFFFFFC, 0));
    #1;
    checks++;
    if (jump_target !== 32'h4FFFFFFC) begin
      errors++;
      $display("FAIL jt_upper: jump_target=%h want 4ffffffc", jump_target);
    end
    sb.push_back('{"jupper_pc", 32'h4FFFFFFC, 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (pc !== e.pc) begin
      errors++;
      $display("FAIL %s: pc=%h want %h", e.name, pc, e.pc);
    end
    do_reset();
    apply(mk("jzero", 1, 0, 16'h0, 1, 26'h2BCDF11, 32'h0AF37C44, 0));
    #1;
    checks++;
    if (jump_target !== 32'h0AF37C44) begin
      errors++;
      $display("FAIL jt_zero: jump_target=%h want 0af37c44", jump_target);
    end
    sb.push_back('{"jzero_pc", 32'h0AF37C44, 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (pc !== e.pc) begin
      errors++;
      $display("FAIL %s: pc=%h want %h", e.name, pc, e.pc);
    end
    idle();
  endtask

  task automatic test_branch();
    stim_t st[$];
    exp_t  e;
    do_reset();
    st.push_back(mk("b_setup", 1, 0, 16'h0, 1, 26'h40, 32'h100, 0));
    st.push_back(mk("b_minus1", 1, 1, 16'hFFFF, 0, 26'h0, 32'h100, 0));
    st.push_back(mk("b_plus3", 1, 1, 16'h0003, 0, 26'h0, 32'h110, 0));
    st.push_back(mk("b_vs_jump", 1, 1, 16'h0003, 1, 26'h40, 32'h100, 0));
    st.push_back(mk("b_jump_back", 1, 0, 16'h0, 1, 26'h0, 32'h0, 0));
    st.push_back(mk("b_wrap_neg", 1, 1, 16'hFFFE, 0, 26'h0, 32'hFFFFFFFC, 0));
    st.push_back(mk("b_wrap_pos", 1, 1, 16'h7FFF, 0, 26'h0, 32'h0001FFFC, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back('{st[i].name, st[i].epc, st[i].erp});
      tick();
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || redirect_pending !== e.rp || pc_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s: pc=%h rp=%b pv=%b want pc=%h rp=%b pv=1",
                 e.name, pc, redirect_pending, pc_valid, e.pc, e.rp);
      end
    end
    idle();
  endtask

  task automatic test_hold();
    stim_t st[$];
    exp_t  e;
    do_reset();
    st.push_back(mk("h_setup", 1, 0, 16'h0, 1, 26'h4, 32'h10, 0));
    st.push_back(mk("h_latch", 0, 0, 16'h0, 1, 26'h20, 32'h10, 1));
    st.push_back(mk("h_wait1", 0, 0, 16'h0, 0, 26'h0, 32'h10, 1));
    st.push_back(mk("h_wait2", 0, 0, 16'h0, 0, 26'h0, 32'h10, 1));
    st.push_back(mk("h_release", 1, 0, 16'h0, 0, 26'h0, 32'h80, 0));
    st.push_back(mk("h_setup2", 1, 0, 16'h0, 1, 26'h4, 32'h10, 0));
    st.push_back(mk("h_latch2", 0, 0, 16'h0, 1, 26'h20, 32'h10, 1));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back('{st[i].name, st[i].epc, st[i].erp});
      tick();
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || redirect_pending !== e.rp || pc_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s: pc=%h rp=%b pv=%b want pc=%h rp=%b pv=1",
                 e.name, pc, redirect_pending, pc_valid, e.pc, e.rp);
      end
    end
    idle();
    reset = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || redirect_pending !== 1'b0) begin
      errors++;
      $display("FAIL hold_reset: pc=%h pv=%b rp=%b want pc=0 pv=0 rp=0",
               pc, pc_valid, redirect_pending);
    end
    #1;
    reset = 1'b0;
    tick();
    apply(mk("h_after", 1, 0, 16'h0, 0, 26'h0, 32'h4, 0));
    sb.push_back('{"h_pending_lost", 32'h4, 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (pc !== e.pc || redirect_pending !== e.rp || pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: pc=%h rp=%b pv=%b want pc=%h rp=%b pv=1",
               e.name, pc, redirect_pending, pc_valid, e.pc, e.rp);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    exp_t  e;
    do_reset();
    st.push_back(mk("bb_setup", 1, 0, 16'h0, 1, 26'h4, 32'h10, 0));
    st.push_back(mk("bb_latch", 0, 0, 16'h0, 1, 26'h20, 32'h10, 1));
    st.push_back(mk("bb_overwrite", 0, 1, 16'h0004, 0, 26'h0, 32'h10, 1));
    st.push_back(mk("bb_take_new", 1, 0, 16'h0, 0, 26'h0, 32'h24, 0));
    st.push_back(mk("bb_latch2", 0, 0, 16'h0, 1, 26'h20, 32'h24, 1));
    st.push_back(mk("bb_same_cycle", 1, 1, 16'h0001, 0, 26'h0, 32'h2C, 0));
    st.push_back(mk("bb_resume", 1, 0, 16'h0, 0, 26'h0, 32'h30, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back('{st[i].name, st[i].epc, st[i].erp});
      tick();
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || redirect_pending !== e.rp || pc_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s: pc=%h rp=%b pv=%b want pc=%h rp=%b pv=1",
                 e.name, pc, redirect_pending, pc_valid, e.pc, e.rp);
      end
    end
    idle();
  endtask

  task automatic test_jr();
    exp_t        e;
    logic [31:0] want_both;
    logic [31:0] want_alone;
    logic        want_rp;
`ifdef NEXT_PC_JR_EN
    want_both  = 32'h2000;
    want_alone = 32'h2000;
    want_rp    = 1'b1;
`else
    want_both  = 32'h100;
    want_alone = 32'h104;
    want_rp    = 1'b0;
`endif
    do_reset();
    apply(mk("jr_both", 1, 0, 16'h0, 1, 26'h40, 32'h0, 0));
    jr = 1'b1;
    jr_target = 32'h2000;
    sb.push_back('{"jr_vs_jump", want_both, 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (pc !== e.pc || redirect_pending !== e.rp) begin
      errors++;
      $display("FAIL %s: pc=%h rp=%b want pc=%h rp=%b",
               e.name, pc, redirect_pending, e.pc, e.rp);
    end
    apply(mk("jr_stall", 0, 0, 16'h0, 0, 26'h0, 32'h0, 0));
    jr = 1'b1;
    jr_target = 32'h2000;
    sb.push_back('{"jr_stall", want_both, want_rp});
    tick();
    e = sb.pop_front();
    checks++;
    if (pc !== e.pc || redirect_pending !== e.rp) begin
      errors++;
      $display("FAIL %s: pc=%h rp=%b want pc=%h rp=%b",
               e.name, pc, redirect_pending, e.pc, e.rp);
    end
    apply(mk("jr_release", 1, 0, 16'h0, 0, 26'h0, 32'h0, 0));
    sb.push_back('{"jr_release", want_alone, 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (pc !== e.pc || redirect_pending !== e.rp) begin
      errors++;
      $display("FAIL %s: pc=%h rp=%b want pc=%h rp=%b",
               e.name, pc, redirect_pending, e.pc, e.rp);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_hold();
    test_back_to_back();
    test_jr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
